// File: rtl/reg_bus_arb_pkg.sv
// Shared types and default widths for the reg-bus round-robin arbiter.
// Optional feature macro: REG_BUS_ARB_TIMEOUT_EN (BUSY timeout watchdog).
package reg_bus_arb_pkg;

    // Arbiter transfer phases
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    localparam int unsigned RBA_NREQ   = 4;
    localparam int unsigned RBA_AW     = 26;
    localparam int unsigned RBA_DW     = 32;
    localparam int unsigned RBA_BEW    = 4;
    localparam int unsigned RBA_TO_CYC = 512;

endpackage

// File: rtl/reg_bus_arb_rr_arb_sel.sv
// Combinational round-robin pick: first asserted request after the pointer.
// Part of reg_bus_arb (macro REG_BUS_ARB_TIMEOUT_EN does not affect this file).
module rr_arb_sel
    import reg_bus_arb_pkg::*;
#(
    parameter int NREQ = RBA_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);

    assign o_valid = |i_req;

    // Scan ptr+1, ptr+2, ... wrapping at NREQ; the pointer itself is last
    always_comb begin : p_pick
        int   j;
        logic found;
        o_idx = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!found && i_req[j]) begin
                found = 1'b1;
                o_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter sharing one reg-bus target between NREQ initiators.
// Define REG_BUS_ARB_TIMEOUT_EN to add a BUSY watchdog that errors out after TO_CYC cycles.
module reg_bus_arb
    import reg_bus_arb_pkg::*;
#(
    parameter int NREQ   = RBA_NREQ,
    parameter int AW     = RBA_AW,
    parameter int DW     = RBA_DW,
    parameter int BEW    = RBA_BEW,
    parameter int TO_CYC = RBA_TO_CYC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_cs,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    input  logic [NREQ-1:0]          req_wr,
    input  logic [NREQ*BEW-1:0]      req_be,
    output logic [DW-1:0]            req_rdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [NREQ-1:0]          req_timeout,
    output logic                     tgt_cs,
    output logic [AW-1:0]            tgt_addr,
    output logic [DW-1:0]            tgt_wdata,
    output logic                     tgt_wr,
    output logic [BEW-1:0]           tgt_be,
    input  logic [DW-1:0]            tgt_rdata,
    input  logic                     tgt_ack,
    output logic [$clog2(NREQ)-1:0]  gnt_id
);

    localparam int IW = $clog2(NREQ);

    // Reject configurations outside the supported range
    if (NREQ < 2 || NREQ > 8 || TO_CYC < 2) begin : g_bad_cfg
        $error("reg_bus_arb: unsupported NREQ or TO_CYC");
    end

    arb_state_t      r_state, w_state_nxt;
    logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [IW-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic            r_tgt_cs, w_tgt_cs_nxt;
    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic [DW-1:0]   r_rdata, w_rdata_nxt;
    logic            w_sel_valid;
    logic [IW-1:0]   w_sel_idx;
    logic [NREQ-1:0] w_gnt_oh;
    logic            w_expire;

    rr_arb_sel #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_sel (
        .i_req   (req_cs),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_sel_valid),
        .o_idx   (w_sel_idx)
    );

    assign w_gnt_oh = NREQ'(1) << r_gnt_id;

`ifdef REG_BUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYC);

    logic [TW-1:0]   r_timer;
    logic [NREQ-1:0] r_tmo;

    // A same-cycle target ack takes precedence over the watchdog
    assign w_expire = (r_state == ST_BUSY) && !tgt_ack
                   && (r_timer == TW'(TO_CYC - 1));

    // Watchdog timer runs in BUSY, clears in DONE; error flag pulses with the ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_tmo   <= '0;
        end else begin
            r_tmo <= '0;
            if (r_state == ST_BUSY) begin
                r_timer <= r_timer + TW'(1);
                if (w_expire)
                    r_tmo <= w_gnt_oh;
            end else if (r_state == ST_DONE) begin
                r_timer <= '0;
            end
        end
    end

    assign req_timeout = r_tmo;
`else
    assign w_expire    = 1'b0;
    assign req_timeout = '0;
`endif

    // Next-state and registered-output decode for the grant FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_gnt_id_nxt = r_gnt_id;
        w_tgt_cs_nxt = r_tgt_cs;
        w_ack_nxt    = '0;
        w_rdata_nxt  = r_rdata;
        unique case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_gnt_id_nxt = w_sel_idx;
                    w_rr_ptr_nxt = w_sel_idx;
                    w_tgt_cs_nxt = 1'b1;
                    w_state_nxt  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (tgt_ack) begin
                    w_tgt_cs_nxt = 1'b0;
                    w_rdata_nxt  = tgt_rdata;
                    w_ack_nxt    = w_gnt_oh;
                    w_state_nxt  = ST_DONE;
                end else if (w_expire) begin
                    w_tgt_cs_nxt = 1'b0;
                    w_rdata_nxt  = '0;
                    w_ack_nxt    = w_gnt_oh;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_tgt_cs_nxt = 1'b0;
                w_state_nxt  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; rr_ptr starts at NREQ-1 so req 0 wins first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= IW'(NREQ - 1);
            r_gnt_id <= '0;
            r_tgt_cs <= 1'b0;
            r_ack    <= '0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_tgt_cs <= w_tgt_cs_nxt;
            r_ack    <= w_ack_nxt;
            r_rdata  <= w_rdata_nxt;
        end
    end

    assign tgt_cs    = r_tgt_cs;
    assign req_ack   = r_ack;
    assign req_rdata = r_rdata;
    assign gnt_id    = r_gnt_id;

    assign tgt_addr  = req_addr[int'(r_gnt_id)*AW +: AW];
    assign tgt_wdata = req_wdata[int'(r_gnt_id)*DW +: DW];
    assign tgt_wr    = req_wr[r_gnt_id];
    assign tgt_be    = req_be[int'(r_gnt_id)*BEW +: BEW];

endmodule
